// File: rtl/debug_pkg.sv
// Shared debug-transport types: DMI op/status encodings and the initiator state set.
package debug_pkg;

    localparam int unsigned DMI_ADDR_W = 7;
    localparam int unsigned DMI_DATA_W = 32;

    typedef enum logic [1:0] {
        DMI_OP_NOP   = 2'd0,
        DMI_OP_READ  = 2'd1,
        DMI_OP_WRITE = 2'd2,
        DMI_OP_RSVD  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        DMI_SUCCESS = 2'd0,
        DMI_RSVD    = 2'd1,
        DMI_FAILED  = 2'd2,
        DMI_BUSY    = 2'd3
    } dmi_status_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } dmi_init_state_e;

    function automatic logic dmi_op_is_access(input dmi_op_e op);
        return (op == DMI_OP_READ) || (op == DMI_OP_WRITE);
    endfunction

endpackage

// File: rtl/dmi_initiator.sv
// DMI requester: issues one synchronized DTM request to the debug module, waits for
// dmi_finish (with timeout), returns data/status and keeps the sticky dmistat.
module dmi_initiator
    import debug_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned DRAIN_CYCLES   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [DMI_ADDR_W-1:0] req_addr,
    input  logic [DMI_DATA_W-1:0] req_data,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_op,
    output logic [DMI_DATA_W-1:0] rsp_data,
    input  logic                  dmireset,
    input  logic                  dmihardreset,
    output logic [1:0]            dmistat,
    output logic                  dmi_start,
    output logic [1:0]            dmi_op,
    output logic [DMI_ADDR_W-1:0] dmi_address,
    output logic [DMI_DATA_W-1:0] dmi_data_o,
    input  logic                  dmi_finish,
    input  logic [DMI_DATA_W-1:0] dmi_data_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TMO   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_DRAIN = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    dmi_init_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    dmi_status_e           r_sticky, w_sticky_nxt, w_sticky_eff;
    dmi_status_e           r_rsp_op, w_rsp_op_nxt;
    logic [DMI_DATA_W-1:0] r_rsp_data, w_rsp_data_nxt;
    dmi_op_e               r_dmi_op, w_dmi_op_nxt;
    logic [DMI_ADDR_W-1:0] r_dmi_addr, w_dmi_addr_nxt;
    logic [DMI_DATA_W-1:0] r_dmi_data, w_dmi_data_nxt;
    dmi_op_e               w_req_op;
    logic [CNT_W-1:0]      w_cnt_inc;

    assign w_req_op  = dmi_op_e'(req_op);
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_sticky   <= DMI_SUCCESS;
            r_rsp_op   <= DMI_SUCCESS;
            r_rsp_data <= '0;
            r_dmi_op   <= DMI_OP_NOP;
            r_dmi_addr <= '0;
            r_dmi_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sticky   <= w_sticky_nxt;
            r_rsp_op   <= w_rsp_op_nxt;
            r_rsp_data <= w_rsp_data_nxt;
            r_dmi_op   <= w_dmi_op_nxt;
            r_dmi_addr <= w_dmi_addr_nxt;
            r_dmi_data <= w_dmi_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_rsp_op_nxt   = r_rsp_op;
        w_rsp_data_nxt = r_rsp_data;
        w_dmi_op_nxt   = r_dmi_op;
        w_dmi_addr_nxt = r_dmi_addr;
        w_dmi_data_nxt = r_dmi_data;
        // dmireset clears first so a same-cycle request or set event sees the cleared value
        w_sticky_eff   = dmireset ? DMI_SUCCESS : r_sticky;
        w_sticky_nxt   = w_sticky_eff;

        if (dmihardreset) begin
            w_state_nxt  = ST_DRAIN;
            w_cnt_nxt    = '0;
            w_sticky_nxt = DMI_SUCCESS;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (dmi_op_is_access(w_req_op) && (w_sticky_eff == DMI_SUCCESS)) begin
                            w_dmi_op_nxt   = w_req_op;
                            w_dmi_addr_nxt = req_addr;
                            w_dmi_data_nxt = req_data;
                            w_state_nxt    = ST_ISSUE;
                        end else begin
                            w_rsp_op_nxt = w_sticky_eff;
                            w_state_nxt  = ST_RESP;
                        end
                    end
                end
                ST_ISSUE: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    if (dmi_finish) begin
                        if (r_dmi_op == DMI_OP_READ) begin
                            w_rsp_data_nxt = dmi_data_i;
                        end
                        w_rsp_op_nxt = DMI_SUCCESS;
                        w_state_nxt  = ST_RESP;
                    end else if (r_cnt == CNT_TMO) begin
                        w_rsp_op_nxt = DMI_FAILED;
                        w_sticky_nxt = DMI_FAILED;
                        w_state_nxt  = ST_RESP;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                ST_RESP: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_DRAIN: begin
                    if (r_cnt >= CNT_DRAIN) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase

            // request while busy is dropped; FAILED outranks BUSY
            if (req_valid && (r_state != ST_IDLE) && (w_sticky_nxt != DMI_FAILED)) begin
                w_sticky_nxt = DMI_BUSY;
            end
        end
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign rsp_valid   = (r_state == ST_RESP);
    assign dmi_start   = (r_state == ST_ISSUE);
    assign rsp_op      = r_rsp_op;
    assign rsp_data    = r_rsp_data;
    assign dmistat     = r_sticky;
    assign dmi_op      = r_dmi_op;
    assign dmi_address = r_dmi_addr;
    assign dmi_data_o  = r_dmi_data;

endmodule
